// File: rtl/iq_demod_pkg.sv
// iq_demod_pkg: shared types, defaults and quadrant-to-IQ mapping for the LO controller
package iq_demod_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} lo_state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;
  localparam logic [2:0] LO_DIV_DEFAULT = 3'd4;
  // Packed as {cos[1:0], sin[1:0]}, each a 2-bit signed sample.
  function automatic logic [3:0] quad_to_iq(quad_t q);
    return q == Q0 ? 4'b0100 : q == Q1 ? 4'b0001 : q == Q2 ? 4'b1100 : 4'b0011;
  endfunction
endpackage

// File: rtl/lo_prescaler.sv
// lo_prescaler: 3-bit divider counting 0..div, ticking on the last count of each quarter
module lo_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic [2:0] i_div,
  output logic       o_tick
);
  logic [2:0] r_cnt;
  assign o_tick = !i_clear && r_cnt == i_div;
  // Counter holds at zero while cleared and wraps after the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else r_cnt <= (i_clear || o_tick) ? '0 : r_cnt + 3'd1;
  end
endmodule

// File: rtl/iq_lo_ctrl.sv
// iq_lo_ctrl: quadrature LO generator with config handshake, bounded/continuous runs and graceful stop
module iq_lo_ctrl
  import iq_demod_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_div,
  input  logic [1:0]        cfg_phase,
  input  logic [7:0]        cfg_nper,
  input  logic              start,
  input  logic              stop,
  output logic signed [1:0] cos_out,
  output logic signed [1:0] sin_out,
  output logic              step,
  output logic              period_done,
  output logic              busy,
  output logic              done
);
  lo_state_t  r_state, w_state_n;
  quad_t      r_quad, w_quad_n, r_phase, w_phase;
  logic [2:0] r_div, w_div;
  logic [7:0] r_nper, w_nper, r_pcnt, w_pcnt_n;
  logic       r_stop, w_hs, w_tick, w_stop_eff, w_step, w_pd;
  logic [3:0] w_iq;

  lo_prescaler u_presc (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != RUN),
    .i_div   (r_div),
    .o_tick  (w_tick)
  );

  assign w_iq = quad_to_iq(w_quad_n);

  // Next state: a config offered alongside start is used immediately; a stop
  // (pending or arriving on the boundary) ends the run without advancing the quadrant.
  always_comb begin
    w_hs       = cfg_valid && cfg_ready;
    w_div      = w_hs ? cfg_div : r_div;
    w_phase    = w_hs ? quad_t'(cfg_phase) : r_phase;
    w_nper     = w_hs ? cfg_nper : r_nper;
    w_stop_eff = r_stop || stop;
    w_state_n  = r_state;
    w_quad_n   = r_quad;
    w_pcnt_n   = r_pcnt;
    w_step     = 1'b0;
    w_pd       = 1'b0;
    if (r_state == IDLE && start) begin
      w_state_n = RUN;
      w_quad_n  = w_phase;
      w_pcnt_n  = '0;
    end else if (r_state == FINISH) begin
      w_state_n = IDLE;
    end else if (r_state == RUN && w_tick) begin
      if (w_stop_eff) begin
        w_state_n = FINISH;
      end else begin
        w_quad_n = quad_t'(r_quad + 2'd1);
        w_step   = 1'b1;
        w_pd     = w_quad_n == r_phase;
        w_pcnt_n = r_pcnt + {7'd0, w_pd};
        if (w_pd && r_nper != 8'd0 && w_pcnt_n == r_nper) w_state_n = FINISH;
      end
    end
  end

  // State, shadow config and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_quad      <= Q0;
      r_div       <= LO_DIV_DEFAULT;
      r_phase     <= Q0;
      r_nper      <= '0;
      r_pcnt      <= '0;
      r_stop      <= 1'b0;
      cos_out     <= '0;
      sin_out     <= '0;
      step        <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_quad      <= w_quad_n;
      r_div       <= w_div;
      r_phase     <= w_phase;
      r_nper      <= w_nper;
      r_pcnt      <= w_pcnt_n;
      r_stop      <= w_state_n == RUN && (r_stop || (r_state == RUN && stop));
      cos_out     <= w_state_n == RUN ? w_iq[3:2] : 2'b00;
      sin_out     <= w_state_n == RUN ? w_iq[1:0] : 2'b00;
      step        <= w_step;
      period_done <= w_pd;
      busy        <= w_state_n != IDLE;
      done        <= w_state_n == FINISH;
      cfg_ready   <= w_state_n == IDLE;
    end
  end
endmodule

// File: tb/tb_iq_lo_ctrl.sv
// tb_iq_lo_ctrl: directed table and sequence checks for the quadrature LO controller
module tb_iq_lo_ctrl;
  logic clk = 1'b0;
  logic reset, cfg_valid, start, stop;
  logic [2:0] cfg_div;
  logic [1:0] cfg_phase;
  logic [7:0] cfg_nper;
  logic cfg_ready, step, period_done, busy, done;
  logic signed [1:0] cos_out, sin_out;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic st, sp, cv;
    logic [2:0] dv;
    logic [1:0] ph;
    logic [7:0] np;
    int b, c, s, stp, pd, d, r;
  } vec_t;
  vec_t tbl[19];

  iq_lo_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_nper(cfg_nper),
    .start(start), .stop(stop), .cos_out(cos_out), .sin_out(sin_out),
    .step(step), .period_done(period_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(int st, int sp, int cv, int dv, int ph, int np,
                             int b, int c, int s, int stp, int pd, int d, int r);
    vec_t x;
    x.st = st[0]; x.sp = sp[0]; x.cv = cv[0];
    x.dv = dv[2:0]; x.ph = ph[1:0]; x.np = np[7:0];
    x.b = b; x.c = c; x.s = s; x.stp = stp; x.pd = pd; x.d = d; x.r = r;
    return x;
  endfunction

  function automatic int cq(int q);
    return q == 0 ? 1 : q == 2 ? -1 : 0;
  endfunction

  function automatic int sq(int q);
    return q == 1 ? 1 : q == 3 ? -1 : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic chk_out(string t, int b, int c, int s, int st, int pd, int d, int r);
    chk({t, ".busy"}, busy, b);
    chk({t, ".cos"}, cos_out, c);
    chk({t, ".sin"}, sin_out, s);
    chk({t, ".step"}, step, st);
    chk({t, ".period_done"}, period_done, pd);
    chk({t, ".done"}, done, d);
    chk({t, ".cfg_ready"}, cfg_ready, r);
  endtask

  task automatic set_cfg(int cv, int dv, int ph, int np);
    cfg_valid = cv[0];
    cfg_div = dv[2:0];
    cfg_phase = ph[1:0];
    cfg_nper = np[7:0];
  endtask

  initial begin
    // Bounded run: div=1, phase=Q2, nper=2; row 3 offers a config during RUN that must be ignored.
    tbl[0]  = v(1,0,1,1,2,2, 1,-1, 0,0,0,0,0);
    tbl[1]  = v(0,0,0,0,0,0, 1,-1, 0,0,0,0,0);
    tbl[2]  = v(0,0,0,0,0,0, 1, 0,-1,1,0,0,0);
    tbl[3]  = v(0,0,1,0,1,5, 1, 0,-1,0,0,0,0);
    tbl[4]  = v(0,0,0,0,0,0, 1, 1, 0,1,0,0,0);
    tbl[5]  = v(0,0,0,0,0,0, 1, 1, 0,0,0,0,0);
    tbl[6]  = v(0,0,0,0,0,0, 1, 0, 1,1,0,0,0);
    tbl[7]  = v(0,0,0,0,0,0, 1, 0, 1,0,0,0,0);
    tbl[8]  = v(0,0,0,0,0,0, 1,-1, 0,1,1,0,0);
    tbl[9]  = v(0,0,0,0,0,0, 1,-1, 0,0,0,0,0);
    tbl[10] = v(0,0,0,0,0,0, 1, 0,-1,1,0,0,0);
    tbl[11] = v(0,0,0,0,0,0, 1, 0,-1,0,0,0,0);
    tbl[12] = v(0,0,0,0,0,0, 1, 1, 0,1,0,0,0);
    tbl[13] = v(0,0,0,0,0,0, 1, 1, 0,0,0,0,0);
    tbl[14] = v(0,0,0,0,0,0, 1, 0, 1,1,0,0,0);
    tbl[15] = v(0,0,0,0,0,0, 1, 0, 1,0,0,0,0);
    tbl[16] = v(0,0,0,0,0,0, 1, 0, 0,1,1,1,0);
    tbl[17] = v(0,0,0,0,0,0, 0, 0, 0,0,0,0,1);
    tbl[18] = v(0,1,0,0,0,0, 0, 0, 0,0,0,0,1);

    start = 0; stop = 0; set_cfg(0, 0, 0, 0);
    reset = 0;
    #1 reset = 1;
    #1 chk_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_out("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc();
    chk_out("rst_release", 0, 0, 0, 0, 0, 0, 1);

    // Default continuous run: Q0 for 5 cycles, steps every 5, period_done on return to Q0.
    start = 1;
    cyc();
    start = 0;
    for (int c = 1; c <= 25; c++) begin
      chk_out($sformatf("def_c%0d", c), 1, cq(((c - 1) / 5) % 4), sq(((c - 1) / 5) % 4),
              int'(c > 1 && (c - 1) % 5 == 0), int'(c == 21), 0, 0);
      stop = (c == 25);
      cyc();
    end
    stop = 0;
    chk_out("def_finish", 1, 0, 0, 0, 0, 1, 0);
    cyc();
    chk_out("def_idle", 0, 0, 0, 0, 0, 0, 1);

    // Stop on the 2nd cycle of Q1: Q1 still lasts 5 cycles, then FINISH, never Q2.
    start = 1;
    cyc();
    start = 0;
    for (int c = 1; c <= 10; c++) begin
      chk_out($sformatf("stop_c%0d", c), 1, cq((c - 1) / 5), sq((c - 1) / 5),
              int'(c == 6), 0, 0, 0);
      stop = (c == 7);
      cyc();
    end
    chk_out("stop_finish", 1, 0, 0, 0, 0, 1, 0);
    cyc();
    chk_out("stop_idle", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st; stop = tbl[i].sp;
      set_cfg(int'(tbl[i].cv), int'(tbl[i].dv), int'(tbl[i].ph), int'(tbl[i].np));
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].stp,
              tbl[i].pd, tbl[i].d, tbl[i].r);
    end
    stop = 0; set_cfg(0, 0, 0, 0);

    // Config with start, div=0: quadrant advances every cycle from the first RUN cycle.
    set_cfg(1, 0, 0, 0); start = 1;
    cyc();
    set_cfg(0, 0, 0, 0); start = 0;
    for (int c = 1; c <= 5; c++) begin
      chk_out($sformatf("div0_c%0d", c), 1, cq((c - 1) % 4), sq((c - 1) % 4),
              int'(c > 1), int'(c == 5), 0, 0);
      stop = (c == 5);
      cyc();
    end
    stop = 0;
    chk_out("div0_finish", 1, 0, 0, 0, 0, 1, 0);
    cyc();
    chk_out("div0_idle", 0, 0, 0, 0, 0, 0, 1);

    // nper=1 with stop on the last Q3 cycle: one FINISH, one done.
    set_cfg(1, 1, 0, 1); start = 1;
    cyc();
    set_cfg(0, 0, 0, 0); start = 0;
    for (int c = 1; c <= 8; c++) begin
      chk_out($sformatf("coin_c%0d", c), 1, cq((c - 1) / 2), sq((c - 1) / 2),
              int'(c > 1 && c % 2 == 1), 0, 0, 0);
      stop = (c == 8);
      cyc();
    end
    stop = 0;
    chk("coin_fin.done", done, 1);
    chk("coin_fin.busy", busy, 1);
    chk("coin_fin.cos", cos_out, 0);
    chk("coin_fin.sin", sin_out, 0);
    cyc();
    chk_out("coin_idle", 0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk_out("coin_idle2", 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-RUN: outputs drop before the next edge, no done, defaults restored.
    set_cfg(1, 3, 1, 0); start = 1;
    cyc();
    set_cfg(0, 0, 0, 0); start = 0;
    chk_out("abort_c1", 1, 0, 1, 0, 0, 0, 0);
    cyc();
    #2 reset = 1;
    #1 chk_out("abort_async", 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_out("abort_hold", 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 0;
    cyc();
    chk_out("abort_release", 0, 0, 0, 0, 0, 0, 1);
    start = 1;
    cyc();
    start = 0;
    for (int c = 1; c <= 6; c++) begin
      chk_out($sformatf("post_c%0d", c), 1, cq((c - 1) / 5), sq((c - 1) / 5),
              int'(c == 6), 0, 0, 0);
      stop = (c == 6);
      cyc();
    end
    stop = 0;
    for (int c = 7; c <= 10; c++) cyc();
    chk_out("post_finish", 1, 0, 0, 0, 0, 1, 0);
    cyc();
    chk_out("post_idle", 0, 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_lo_ctrl.md
IQ_LO_CTRL -- requirements
Module: iq_lo_ctrl

Interface
REQ-001 SHALL have ports in this order (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- cfg_valid, in, 1: configuration offered.
- cfg_ready, out, 1: configuration accepted when high with cfg_valid.
- cfg_div, in, 3: quarter-phase length minus 1, in cycles.
- cfg_phase, in, 2: starting quadrant.
- cfg_nper, in, 8: full LO periods to generate; 0 = continuous.
- start, in, 1: begin generation.
- stop, in, 1: request end of generation.
- cos_out, out, signed 2: in-phase LO sample.
- sin_out, out, signed 2: quadrature LO sample.
- step, out, 1: one-cycle pulse, first cycle of a new quadrant.
- period_done, out, 1: one-cycle pulse, a full period completed.
- busy, out, 1: high in RUN and FINISH.
- done, out, 1: one-cycle pulse when a run ends.

Function
REQ-002 SHALL implement states IDLE, RUN, FINISH.
REQ-003 SHALL drive cfg_ready=1 only in IDLE.
REQ-004 SHALL latch cfg_div, cfg_phase and cfg_nper into shadow registers on a cfg_valid&&cfg_ready cycle.
REQ-005 SHALL use the configuration transferred in the same cycle when a handshake and start coincide in IDLE.
REQ-006 SHALL respond to start sampled high in IDLE at edge N as follows:
- state=RUN, quadrant=shadow phase, divider=0, period count=0 from edge N+1;
- busy=1 from edge N+1.
REQ-007 SHALL ignore start outside IDLE and stop outside RUN.
REQ-008 SHALL map quadrant to (cos_out, sin_out) as Q0=(1,0), Q1=(0,1), Q2=(-1,0), Q3=(0,-1); all outputs registered.
REQ-009 SHALL drive cos_out=sin_out=0 in IDLE and FINISH.
REQ-010 SHALL run the divider 0..div in RUN; at div it returns to 0, the quadrant advances mod 4 (Q0->Q1->Q2->Q3->Q0) and step pulses with the new quadrant.
REQ-011 SHALL, with div=0, advance the quadrant and pulse step every RUN cycle.
REQ-012 SHALL pulse period_done with the step that returns the quadrant to the shadow phase, and increment the 8-bit period count on that step.
REQ-013 SHALL enter FINISH on the step where the period count reaches nper, when nper!=0.
REQ-014 SHALL keep running continuously when nper=0, with the period count wrapping mod 256.
REQ-015 SHALL record stop sampled in RUN as pending and enter FINISH at the next quarter boundary, so no quarter is truncated; the quadrant does not advance on that boundary.
REQ-016 SHALL treat stop and the nper boundary on the same cycle as a single FINISH entry.
REQ-017 SHALL make FINISH last exactly one cycle: done=1, busy=1, then IDLE.

Reset
REQ-018 SHALL, while reset is high, immediately force:
- state=IDLE, cos_out=sin_out=0;
- step=period_done=done=busy=0, cfg_ready=0;
- shadow div=4, phase=Q0, nper=0;
- divider, period count and stop-pending cleared.
REQ-019 SHALL raise cfg_ready on the first edge after reset deasserts.
REQ-020 SHALL abort a run on reset assertion mid-RUN without pulsing done.

Structure
REQ-021 SHALL take from shared package iq_demod_pkg:
- lo_state_t enum {IDLE, RUN, FINISH};
- quad_t enum {Q0..Q3};
- constant LO_DIV_DEFAULT=4;
- function quad_to_iq returning the 2-bit signed pair.
REQ-022 SHALL instantiate one sub-module lo_prescaler (3-bit divider with clear and tick output); all other logic lives in iq_lo_ctrl.

Verification
REQ-023 Default run: reset, start at cycle 10, nper=0 -> busy from 11; Q0 at 11-15, Q1 at 16-20; step at 16, 21, 26, 31; period_done at 31.
REQ-024 Bounded run: cfg div=1, phase=2, nper=2, start -> sequence Q2,Q3,Q0,Q1 twice, 2 cycles each; period_done twice; done exactly one cycle after the 16th RUN cycle; outputs 0 afterwards.
REQ-025 Stop mid-quarter: div=4, stop on the 2nd cycle of Q1 -> Q1 held for its full 5 cycles, FINISH, done, IDLE; no Q2 observed.
REQ-026 Handshake: cfg_valid during RUN -> cfg_ready=0, shadow unchanged; cfg_valid with start in IDLE, div=0 -> quadrant changes every cycle from the first RUN cycle.
REQ-027 Reset abort: reset asserted asynchronously mid-RUN (between edges) -> outputs 0 before the next edge, no done pulse, cfg_ready=1 on the first edge after release.
REQ-028 Coincident stop and nper boundary: nper=1, stop on the last Q3 cycle -> a single FINISH, a single done pulse.
